// File: rtl/dlfloat_pkg.sv
// Shared DLFloat constants and the operand-sequencer state encoding.
package dlfloat_pkg;

   localparam int DLF_W    = 16;
   localparam int EXP_W    = 6;
   localparam int MAN_W    = 9;
   localparam int DLF_BIAS = 31;

   localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
   localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ISSUE = 2'd2,
      S_DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/dlfloat_operand_cond.sv
// Operand conditioning for one DLFloat value: NaN detect and optional flush-to-zero.
// The all-ones NaN pattern is never flushed, even though its exponent is non-zero anyway.
module dlfloat_operand_cond
   import dlfloat_pkg::*;
#(
   parameter bit FTZ = 1'b1
) (
   input  logic [DLF_W-1:0] raw,
   output logic [DLF_W-1:0] cond,
   output logic             is_nan
);

   // Pass-through by default; zero-exponent values collapse to +0 when flushing.
   always_comb begin
      is_nan = (raw == DLF_NAN);
      cond   = raw;
      if (!is_nan && FTZ && (raw[MAN_W +: EXP_W] == '0)) begin
         cond = DLF_ZERO;
      end
   end

endmodule

// File: rtl/dlfloat_operand_sequencer.sv
// Byte-stream to DLFloat operand-pair sequencer framing one dot product for the MAC.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both
// high; valid-side data is held stable until that edge, ready never depends on valid.
module dlfloat_operand_sequencer
   import dlfloat_pkg::*;
#(
   parameter int VLEN_W = 8,
   parameter bit FTZ    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [VLEN_W-1:0] vec_len,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DLF_W-1:0]  op_a,
   output logic [DLF_W-1:0]  op_b,
   output logic              op_valid,
   input  logic              op_ready,
   output logic              acc_clear,
   output logic              op_last,
   output logic              busy,
   output logic              done,
   output logic              nan_seen,
   output seq_state_e        dbg_state
);

   seq_state_e        state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [VLEN_W-1:0] pair_cnt_q, pair_cnt_d;
   logic [VLEN_W-1:0] len_q, len_d;
   logic              first_q, first_d;
   logic              nan_q, nan_d;
   logic [DLF_W-1:0]  a_asm_q, a_asm_d;
   logic [7:0]        b_lo_q, b_lo_d;
   logic [DLF_W-1:0]  op_a_q, op_a_d;
   logic [DLF_W-1:0]  op_b_q, op_b_d;

   logic [DLF_W-1:0]  raw_b, cond_a, cond_b;
   logic              nan_a, nan_b, last_pair;

   // B is conditioned on the edge its high byte arrives, so its top half comes straight from the bus.
   assign raw_b     = {in_data, b_lo_q};
   // len_q is never zero while a pair is outstanding, so the subtraction cannot underflow.
   assign last_pair = (pair_cnt_q == (len_q - VLEN_W'(1)));

   dlfloat_operand_cond #(.FTZ(FTZ)) u_cond_a (
      .raw    (a_asm_q),
      .cond   (cond_a),
      .is_nan (nan_a)
   );

   dlfloat_operand_cond #(.FTZ(FTZ)) u_cond_b (
      .raw    (raw_b),
      .cond   (cond_b),
      .is_nan (nan_b)
   );

   // Next-state logic: byte assembly in LOAD, single pair hand-off in ISSUE.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      pair_cnt_d = pair_cnt_q;
      len_d      = len_q;
      first_d    = first_q;
      nan_d      = nan_q;
      a_asm_d    = a_asm_q;
      b_lo_d     = b_lo_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               nan_d = 1'b0;
               if (vec_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_LOAD;
                  len_d      = vec_len;
                  pair_cnt_d = '0;
                  byte_cnt_d = 2'd0;
                  first_d    = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               unique case (byte_cnt_q)
                  2'd0: a_asm_d[7:0]  = in_data;
                  2'd1: a_asm_d[15:8] = in_data;
                  2'd2: b_lo_d        = in_data;
                  default: begin
                     op_a_d  = cond_a;
                     op_b_d  = cond_b;
                     nan_d   = nan_q | nan_a | nan_b;
                     state_d = S_ISSUE;
                  end
               endcase
            end
         end
         S_ISSUE: begin
            if (op_ready) begin
               pair_cnt_d = pair_cnt_q + VLEN_W'(1);
               first_d    = 1'b0;
               state_d    = last_pair ? S_DONE : S_LOAD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partially assembled pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         pair_cnt_q <= '0;
         len_q      <= '0;
         first_q    <= 1'b0;
         nan_q      <= 1'b0;
         a_asm_q    <= '0;
         b_lo_q     <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         pair_cnt_q <= pair_cnt_d;
         len_q      <= len_d;
         first_q    <= first_d;
         nan_q      <= nan_d;
         a_asm_q    <= a_asm_d;
         b_lo_q     <= b_lo_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign op_valid  = (state_q == S_ISSUE);
   assign acc_clear = op_valid & first_q;
   assign op_last   = op_valid & last_pair;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign nan_seen  = nan_q;
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dlfloat_operand_sequencer.sv
// Self-checking bench for dlfloat_operand_sequencer: directed scenarios plus random vectors.
module tb_dlfloat_operand_sequencer;
   import dlfloat_pkg::*;

   localparam int VLEN_W = 8;
   localparam bit FTZ    = 1'b1;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              start    = 1'b0;
   logic [VLEN_W-1:0] vec_len  = '0;
   logic [7:0]        in_data  = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [15:0]       op_a, op_b;
   logic              op_valid;
   logic              op_ready = 1'b0;
   logic              acc_clear, op_last, busy, done, nan_seen;
   seq_state_e        dbg_state;

   int checks = 0;
   int errors = 0;

   // Expected pair record: {nan_so_far, first, last, op_a, op_b}
   logic [34:0] exp_q[$];
   logic [15:0] raw_a[16];
   logic [15:0] raw_b[16];

   dlfloat_operand_sequencer #(.VLEN_W(VLEN_W), .FTZ(FTZ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vec_len   (vec_len),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .acc_clear (acc_clear),
      .op_last   (op_last),
      .busy      (busy),
      .done      (done),
      .nan_seen  (nan_seen),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference conditioning from the value rules
   function automatic logic [15:0] cond_ref(input logic [15:0] raw);
      int exp_field;
      if (raw == 16'hFFFF) return raw;
      exp_field = (int'(raw) / 512) % 64;
      if (FTZ && exp_field == 0) return 16'h0000;
      return raw;
   endfunction

   function automatic logic [15:0] rand_operand();
      logic [15:0] v;
      v = 16'($urandom());
      case ($urandom_range(0, 3))
         0:       v = 16'hFFFF;
         1:       v = {v[15], 6'd0, v[8:0]};
         default: ;
      endcase
      return v;
   endfunction

   task automatic build_model(input int len);
      bit nan;
      nan = 1'b0;
      exp_q.delete();
      for (int i = 0; i < len; i++) begin
         nan = nan | (raw_a[i] == 16'hFFFF) | (raw_b[i] == 16'hFFFF);
         exp_q.push_back({nan, (i == 0), (i == len - 1), cond_ref(raw_a[i]), cond_ref(raw_b[i])});
      end
   endtask

   // Present one byte and hold it until it is taken
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) chk("byte_wait_timeout", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_vector(input int len, input int stall_pair, input int stall_cycles,
                             input bit gaps, input bit extra_start);
      logic [34:0] rec;
      logic [7:0]  b_v;
      build_model(len);
      vec_len = VLEN_W'(len);
      start   = 1'b1;
      tick();
      start   = 1'b0;
      vec_len = '0;
      chk("start_busy", busy, 1);
      chk("start_nan_clear", nan_seen, 0);
      chk("start_in_ready", in_ready, 1);
      for (int p = 0; p < len; p++) begin
         for (int k = 0; k < 4; k++) begin
            case (k)
               0:       b_v = raw_a[p][7:0];
               1:       b_v = raw_a[p][15:8];
               2:       b_v = raw_b[p][7:0];
               default: b_v = raw_b[p][15:8];
            endcase
            if (gaps) begin
               in_valid = 1'b0;
               tick();
            end
            if (extra_start && p == 0 && k == 1) begin
               start   = 1'b1;
               vec_len = 8'd5;
               tick();
               start   = 1'b0;
               vec_len = '0;
            end
            send_byte(b_v);
         end
         rec = exp_q.pop_front();
         chk("issue_valid", op_valid, 1);
         chk("issue_op_a", op_a, rec[31:16]);
         chk("issue_op_b", op_b, rec[15:0]);
         chk("issue_acc_clear", acc_clear, rec[33]);
         chk("issue_op_last", op_last, rec[32]);
         chk("issue_nan_seen", nan_seen, rec[34]);
         chk("issue_in_ready", in_ready, 0);
         if (p == stall_pair) begin
            for (int s = 0; s < stall_cycles; s++) begin
               tick();
               chk("stall_valid", op_valid, 1);
               chk("stall_op_a", op_a, rec[31:16]);
               chk("stall_op_b", op_b, rec[15:0]);
               chk("stall_acc_clear", acc_clear, rec[33]);
               chk("stall_op_last", op_last, rec[32]);
               chk("stall_in_ready", in_ready, 0);
            end
         end
         op_ready = 1'b1;
         tick();
         op_ready = 1'b0;
         chk("post_accept_valid", op_valid, 0);
         if (p == len - 1) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
         end else begin
            chk("mid_done", done, 0);
            chk("mid_in_ready", in_ready, 1);
         end
      end
      tick();
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);
      chk("after_valid", op_valid, 0);
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      tick();
      tick();
      chk("reset_state", dbg_state, S_IDLE);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_op_valid", op_valid, 0);
      chk("reset_op_a", op_a, 0);
      chk("reset_op_b", op_b, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_nan", nan_seen, 0);
      rst_n = 1'b1;
      tick();

      // Single pair 1.0 x 2.0
      raw_a[0] = 16'h3E00;
      raw_b[0] = 16'h4000;
      run_vector(1, -1, 0, 1'b0, 1'b0);

      // Backpressure on pair 2 of 3
      for (int i = 0; i < 3; i++) begin
         raw_a[i] = rand_operand();
         raw_b[i] = rand_operand();
      end
      run_vector(3, 1, 5, 1'b0, 1'b0);

      // Special values: NaN passes, zero exponent flushes
      raw_a[0] = 16'hFFFF;
      raw_b[0] = 16'h0005;
      run_vector(1, -1, 0, 1'b0, 1'b0);
      chk("nan_sticky", nan_seen, 1);
      raw_a[0] = 16'h3C00;
      raw_b[0] = 16'h8123;
      run_vector(1, -1, 0, 1'b0, 1'b0);

      // Zero length
      vec_len = '0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 1);
      chk("zero_valid", op_valid, 0);
      chk("zero_in_ready", in_ready, 0);
      tick();
      chk("zero_done_end", done, 0);
      chk("zero_busy_end", busy, 0);

      // Input gaps plus ignored start mid-LOAD
      for (int i = 0; i < 3; i++) begin
         raw_a[i] = rand_operand();
         raw_b[i] = rand_operand();
      end
      run_vector(3, -1, 0, 1'b1, 1'b1);

      // Reset mid-operation
      vec_len = 8'd1;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      send_byte(8'hAA);
      send_byte(8'h55);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", dbg_state, S_IDLE);
      chk("async_rst_in_ready", in_ready, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_valid", op_valid, 0);
      chk("async_rst_done", done, 0);
      tick();
      rst_n = 1'b1;
      tick();
      raw_a[0] = 16'h3E00;
      raw_b[0] = 16'h3E00;
      run_vector(1, -1, 0, 1'b0, 1'b0);

      // Random vectors
      for (int v = 0; v < 8; v++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            raw_a[i] = rand_operand();
            raw_b[i] = rand_operand();
         end
         run_vector(len, $urandom_range(0, len - 1), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
